// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory/writeback stage.
// Contents: opcode map, byte-enable codes, FSM state type and opcode classifiers.
package mem_wb_stage_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_LUI  = 6'd3;
    localparam logic [5:0] OP_ANDI = 6'd4;
    localparam logic [5:0] OP_ORI  = 6'd5;
    localparam logic [5:0] OP_XORI = 6'd6;
    localparam logic [5:0] OP_LW   = 6'd16;
    localparam logic [5:0] OP_LH   = 6'd18;
    localparam logic [5:0] OP_LB   = 6'd20;
    localparam logic [5:0] OP_SW   = 6'd24;
    localparam logic [5:0] OP_SH   = 6'd26;
    localparam logic [5:0] OP_SB   = 6'd28;
    localparam logic [5:0] OP_JAL  = 6'd41;

    // Byte enables are active-low: a 0 bit enables that byte lane.
    localparam logic [3:0] WREN_W    = 4'b0000;
    localparam logic [3:0] WREN_H    = 4'b1100;
    localparam logic [3:0] WREN_B    = 4'b1110;
    localparam logic [3:0] WREN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        WB
    } state_t;

    function automatic logic is_alu(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LW, OP_LH, OP_LB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SW, OP_SH, OP_SB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Load data alignment: sign-extends halfword/byte loads, passes words through.
module load_extend
    import mem_wb_stage_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] rdata,
    output logic [31:0] ext
);

    always_comb begin
        // NOTE: assign a default first so every path drives ext and no latch is inferred.
        ext = rdata;
        case (op)
            OP_LH:   ext = {{16{rdata[15]}}, rdata[15:0]};
            OP_LB:   ext = {{24{rdata[7]}}, rdata[7:0]};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access and register writeback stage behind the ALU.
// One instruction in flight; loads/stores use a req/rvalid handshake with timeout.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  ex_op,
    input  logic [4:0]  ex_wreg,
    input  logic [3:0]  ex_wren,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_sdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wren_n,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic        busy,
    output logic        err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [5:0]       ld_op;
    logic [31:0]      ld_ext;
    logic             accept;

    // Extension is driven from the live bus data so the result is ready on the rvalid edge.
    load_extend u_load_extend (
        .op    (ld_op),
        .rdata (mem_rdata),
        .ext   (ld_ext)
    );

    assign ex_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = ex_valid & ex_ready;
    assign fwd_valid = rf_we;
    assign fwd_reg   = rf_waddr;
    assign fwd_data  = rf_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            ld_op       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wren_n  <= WREN_NONE;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            err_timeout <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_alu(ex_op)) begin
                            state    <= WB;
                            rf_waddr <= ex_wreg;
                            rf_wdata <= ex_result;
                            rf_we    <= (ex_wreg != 5'd0);
                        end else if (is_load(ex_op)) begin
                            state      <= MEM;
                            tmo_cnt    <= '0;
                            ld_op      <= ex_op;
                            rf_waddr   <= ex_wreg;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= ex_result;
                            mem_wdata  <= ex_sdata;
                            mem_wren_n <= WREN_NONE;
                        end else if (is_store(ex_op)) begin
                            state      <= MEM;
                            tmo_cnt    <= '0;
                            ld_op      <= ex_op;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b1;
                            mem_addr   <= ex_result;
                            mem_wdata  <= ex_sdata;
                            mem_wren_n <= ex_wren;
                        end
                    end
                end
                MEM: begin
                    if (mem_rvalid) begin
                        mem_req <= 1'b0;
                        tmo_cnt <= '0;
                        if (mem_we) begin
                            state <= IDLE;
                        end else begin
                            state    <= WB;
                            rf_wdata <= ld_ext;
                            rf_we    <= (rf_waddr != 5'd0);
                        end
                    end else if (tmo_cnt == CNT_LAST) begin
                        // Abandon the access; the sticky flag tells software it happened.
                        mem_req     <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: scoreboard of expected writebacks plus
// directed checks on handshake timing, timeout and reset behaviour.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int TIMEOUT_CYC = 16;

    logic        clk;
    logic        rstn;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_op;
    logic [4:0]  ex_wreg;
    logic [3:0]  ex_wren;
    logic [31:0] ex_result;
    logic [31:0] ex_sdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wren_n;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        busy;
    logic        err_timeout;

    mem_wb_stage #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_op       (ex_op),
        .ex_wreg     (ex_wreg),
        .ex_wren     (ex_wren),
        .ex_result   (ex_result),
        .ex_sdata    (ex_sdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wren_n  (mem_wren_n),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_reg     (fwd_reg),
        .fwd_data    (fwd_data),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;

    wb_t sb[$];
    wb_t sb_e;

    // Memory model: rvalid in the mem_lat-th request cycle; mem_lat == 0 never answers.
    int          mem_lat      = 1;
    int          req_cycles   = 0;
    logic [31:0] mem_rd_val   = 32'd0;
    logic        stray_rvalid = 1'b0;

    always @(negedge clk) begin
        mem_rdata = mem_rd_val;
        if (mem_req) begin
            mem_rvalid = (mem_lat != 0) && (req_cycles == mem_lat - 1);
            req_cycles++;
        end else begin
            mem_rvalid = stray_rvalid;
            req_cycles = 0;
        end
    end

    // Writeback monitor: every rf_we must match the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && rf_we) begin
            if (sb.size() == 0) begin
                check("unexpected_rf_we", 32'(rf_we), 32'd0);
            end else begin
                sb_e = sb.pop_front();
                check("wb_waddr", 32'(rf_waddr), 32'(sb_e.waddr));
                check("wb_wdata", rf_wdata, sb_e.wdata);
                check("fwd_valid", 32'(fwd_valid), 32'd1);
                check("fwd_reg", 32'(fwd_reg), 32'(sb_e.waddr));
                check("fwd_data", fwd_data, sb_e.wdata);
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [4:0] wreg, input logic [3:0] wren,
                        input logic [31:0] res, input logic [31:0] sd);
        int n = 0;
        @(negedge clk);
        while (!ex_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) check("send_ready_timeout", 32'(ex_ready), 32'd1);
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_wreg   = wreg;
        ex_wren   = wren;
        ex_result = res;
        ex_sdata  = sd;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [5:0] op, input logic [4:0] wreg,
                           input logic [31:0] addr, input logic [31:0] rd, input int lat,
                           input logic [31:0] exp);
        int n;
        mem_lat    = lat;
        mem_rd_val = rd;
        sb.push_back('{wreg, exp});
        send(op, wreg, WREN_W, addr, 32'h0);
        @(negedge clk);
        n = 1;
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_wren_n"}, 32'(mem_wren_n), 32'(WREN_NONE));
        check({tag, "_addr"}, mem_addr, addr);
        while (!rf_we && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat + 1));
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [5:0] alu_ops[5] = '{OP_ADDI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI};

    initial begin
        int n;
        logic [31:0] r;

        rstn      = 1'b0;
        ex_valid  = 1'b0;
        ex_op     = '0;
        ex_wreg   = '0;
        ex_wren   = WREN_NONE;
        ex_result = '0;
        ex_sdata  = '0;
        #12;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_mem_wren_n", 32'(mem_wren_n), 32'hF);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);

        // rvalid while idle must be ignored.
        @(negedge clk);
        rstn         = 1'b1;
        stray_rvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_rvalid_idle", 32'(busy), 32'd0);
        stray_rvalid = 1'b0;

        // ALU op: writeback the cycle after transfer, ready low for one cycle.
        sb.push_back('{5'd5, 32'h1234});
        send(OP_R, 5'd5, WREN_W, 32'h1234, 32'h0);
        check("alu_rf_we_next", 32'(rf_we), 32'd1);
        check("alu_ex_ready_low", 32'(ex_ready), 32'd0);
        @(posedge clk);
        #1;
        check("alu_ex_ready_back", 32'(ex_ready), 32'd1);
        check("alu_rf_we_one_cycle", 32'(rf_we), 32'd0);

        // Store halfword, 3-cycle memory: fields held stable, no writeback.
        mem_lat = 3;
        send(OP_SH, 5'd3, WREN_H, 32'h40, 32'hAABB_CCDD);
        n = 0;
        @(negedge clk);
        while (mem_req && n < 40) begin
            check("sh_mem_we", 32'(mem_we), 32'd1);
            check("sh_wren_n", 32'(mem_wren_n), 32'(WREN_H));
            check("sh_addr", mem_addr, 32'h40);
            check("sh_wdata", mem_wdata, 32'hAABB_CCDD);
            n++;
            @(negedge clk);
        end
        check("sh_req_cycles", 32'(n), 32'd3);
        check("sh_idle_after", 32'(busy), 32'd0);

        // Loads with sign extension and varied latency.
        do_load("lb_neg", OP_LB, 5'd7, 32'h10, 32'h0000_0080, 2, 32'hFFFF_FF80);
        do_load("lh_pos", OP_LH, 5'd8, 32'h11, 32'h1234_7FFF, 1, 32'h0000_7FFF);
        do_load("lh_neg", OP_LH, 5'd9, 32'h12, 32'h0000_8001, 4, 32'hFFFF_8001);
        do_load("lw", OP_LW, 5'd10, 32'h13, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
        do_load("lb_pos", OP_LB, 5'd12, 32'h14, 32'hFFFF_FF7F, 1, 32'h0000_007F);

        // ALU op to r0 retires without a register write.
        send(OP_ADDI, 5'd0, WREN_W, 32'h55, 32'h0);
        check("alu_wreg0_no_we", 32'(rf_we), 32'd0);

        // JAL links into r31.
        sb.push_back('{5'd31, 32'h101});
        send(OP_JAL, 5'd31, WREN_W, 32'h101, 32'h0);

        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            sb.push_back('{5'(i + 1), r});
            send(alu_ops[i], 5'(i + 1), WREN_W, r, 32'h0);
        end
        wait_idle("alu_loop_idle");

        // Unknown opcode: no state change.
        send(6'd7, 5'd4, WREN_W, 32'h77, 32'h0);
        check("unknown_op_busy", 32'(busy), 32'd0);
        check("unknown_op_ready", 32'(ex_ready), 32'd1);

        // Memory never answers: abort after TIMEOUT_CYC request cycles.
        mem_lat = 0;
        send(OP_LW, 5'd13, WREN_W, 32'h20, 32'h0);
        n = 0;
        @(negedge clk);
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 32'(n), 32'(TIMEOUT_CYC));
        check("tmo_err", 32'(err_timeout), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_mem_req", 32'(mem_req), 32'd0);

        sb.push_back('{5'd2, 32'hCAFE});
        send(OP_ORI, 5'd2, WREN_W, 32'hCAFE, 32'h0);
        wait_idle("sticky_idle");
        check("tmo_sticky", 32'(err_timeout), 32'd1);

        // Reset mid-access drops the request immediately.
        send(OP_LW, 5'd14, WREN_W, 32'h30, 32'h0);
        repeat (2) @(negedge clk);
        check("mid_mem_req", 32'(mem_req), 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_err", 32'(err_timeout), 32'd0);
        check("rst_mid_wren_n", 32'(mem_wren_n), 32'hF);
        @(negedge clk);
        rstn         = 1'b1;
        mem_rd_val   = 32'h1111_2222;
        stray_rvalid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_late_rvalid", 32'(busy), 32'd0);
        stray_rvalid = 1'b0;

        sb.push_back('{5'd6, 32'hBEEF_0001});
        send(OP_XORI, 5'd6, WREN_W, 32'hBEEF_0001, 32'h0);
        do_load("post_rst_lw", OP_LW, 5'd15, 32'h44, 32'h0BAD_F00D, 2, 32'h0BAD_F00D);

        wait_idle("final_idle");
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
